// File: rtl/lfsr_prbs_checker_if.sv
// lfsr_prbs_checker_if: received LFSR word stream (valid + state word)
// Ports: in_valid - word present this cycle; in_data - received LFSR state word
interface lfsr_prbs_checker_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  modport master (output in_valid, in_data);
  modport slave  (input  in_valid, in_data);
endinterface

// File: rtl/lfsr_prbs_checker.sv
// lfsr_prbs_checker: self-synchronising Galois LFSR word checker with error statistics
// Ports: clk, rst (sync, active-high); in_if (slave: in_valid, in_data);
//        clr_cnt - clear statistics; locked - predictor in lock; err_pulse - registered
//        mismatch flag while locked; err_cnt/word_cnt - saturating mismatch/valid word counts.
// Option: define LFSR_CHK_BITERR_EN to add bit_err_cnt (saturating bit-error count while locked).
module lfsr_prbs_checker #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] TAP_MASK = WIDTH'('h3400),
  parameter int               LOCK_CNT = 4,
  parameter int               LOSS_CNT = 8,
  parameter int               CNT_W    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  lfsr_prbs_checker_if.slave       in_if,
  input  logic                     clr_cnt,
  output logic                     locked,
  output logic                     err_pulse,
  output logic [CNT_W-1:0]         err_cnt,
  output logic [CNT_W-1:0]         word_cnt
`ifdef LFSR_CHK_BITERR_EN
  ,
  output logic [CNT_W-1:0]         bit_err_cnt
`endif
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  // the MSB only ever receives s[0]; a stray top tap bit is ignored
  localparam logic [WIDTH-1:0] TAPS = TAP_MASK & {1'b0, {(WIDTH-1){1'b1}}};
  typedef enum logic {SEARCH, LOCKED} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] pred_q, pred_d;
  logic [MW-1:0]    match_q, match_d;
  logic [LW-1:0]    miss_q, miss_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d, word_cnt_q, word_cnt_d;
  logic             hit;
  function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] s);
    return {s[0], s[WIDTH-1:1]} ^ (TAPS & {WIDTH{s[0]}});
  endfunction
  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] c);
    return &c ? c : c + CNT_W'(1);
  endfunction
  assign hit = in_if.in_data == pred_q;
  always_comb begin
    state_d    = state_q;
    pred_d     = pred_q;
    match_d    = match_q;
    miss_d     = miss_q;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    word_cnt_d = word_cnt_q;
    if (in_if.in_valid) begin
      if (state_q == SEARCH) begin
        if (in_if.in_data == '0) match_d = '0;
        else begin
          // unseeded or mismatching words re-seed; matches extend the run
          pred_d  = nxt(in_if.in_data);
          match_d = (match_q != '0 && hit) ? match_q + 1'b1 : MW'(1);
          if (match_q == MW'(LOCK_CNT) && hit) begin
            state_d = LOCKED;
            match_d = '0;
          end
        end
      end else begin
        // flywheel: the predictor free-runs, received data is never reloaded
        word_cnt_d = inc(word_cnt_q);
        pred_d     = nxt(pred_q);
        miss_d     = hit ? '0 : miss_q + 1'b1;
        err_d      = !hit;
        err_cnt_d  = hit ? err_cnt_q : inc(err_cnt_q);
        if (!hit && miss_q == LW'(LOSS_CNT - 1)) begin
          state_d = SEARCH;
          miss_d  = '0;
          pred_d  = '0;
          match_d = '0;
        end
      end
    end
    if (clr_cnt) begin
      err_cnt_d  = '0;
      word_cnt_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SEARCH;
      pred_q     <= '0;
      match_q    <= '0;
      miss_q     <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pred_q     <= pred_d;
      match_q    <= match_d;
      miss_q     <= miss_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end
  assign locked    = state_q == LOCKED;
  assign err_pulse = err_q;
  assign err_cnt   = err_cnt_q;
  assign word_cnt  = word_cnt_q;
`ifdef LFSR_CHK_BITERR_EN
  localparam int PW = $clog2(WIDTH + 1);
  logic [PW-1:0]    pop;
  logic [WIDTH-1:0] diff;
  logic [CNT_W:0]   bsum;
  logic [CNT_W-1:0] bit_q, bit_d;
  assign diff = in_if.in_data ^ pred_q;
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + PW'(diff[i]);
    bsum  = {1'b0, bit_q} + (CNT_W+1)'(pop);
    bit_d = (in_if.in_valid && state_q == LOCKED) ? (bsum[CNT_W] ? '1 : bsum[CNT_W-1:0]) : bit_q;
    bit_d = clr_cnt ? '0 : bit_d;
  end
  always_ff @(posedge clk) begin
    if (rst) bit_q <= '0;
    else bit_q <= bit_d;
  end
  assign bit_err_cnt = bit_q;
`endif
endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// tb_lfsr_prbs_checker: directed-vector bench for lfsr_prbs_checker
module tb_lfsr_prbs_checker;
  logic clk = 1'b0, rst = 1'b1, clr = 1'b0;
  logic locked, err_pulse, l2, p2;
  logic [31:0] err_cnt, word_cnt;
  logic [1:0] e2, w2;
  logic [15:0] cur;
  int n_vec = 0, n_miss = 0;
`ifdef LFSR_CHK_BITERR_EN
  logic [31:0] bit_err_cnt;
  logic [1:0] b2;
`endif
  lfsr_prbs_checker_if #(.WIDTH(16)) in_if ();
  lfsr_prbs_checker dut (
    .clk(clk), .rst(rst), .in_if(in_if), .clr_cnt(clr),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .word_cnt(word_cnt)
`ifdef LFSR_CHK_BITERR_EN
    , .bit_err_cnt(bit_err_cnt)
`endif
  );
  lfsr_prbs_checker #(.LOCK_CNT(1), .LOSS_CNT(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_if(in_if), .clr_cnt(clr),
    .locked(l2), .err_pulse(p2), .err_cnt(e2), .word_cnt(w2)
`ifdef LFSR_CHK_BITERR_EN
    , .bit_err_cnt(b2)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] nxt(input logic [15:0] s);
    logic [15:0] tap = 16'h3400;
    logic [15:0] r;
    for (int i = 0; i < 15; i++) r[i] = s[i+1] ^ (tap[i] & s[0]);
    r[15] = s[0];
    return r;
  endfunction
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic step(input logic v, input logic [15:0] d, input logic c);
    @(negedge clk);
    in_if.in_valid = v;
    in_if.in_data  = d;
    clr            = c;
    @(posedge clk);
    #1;
  endtask
  task automatic clean();
    step(1'b1, cur, 1'b0);
    cur = nxt(cur);
  endtask
  task automatic bad(input logic [15:0] m);
    step(1'b1, cur ^ m, 1'b0);
    cur = nxt(cur);
  endtask
  initial begin
    in_if.in_valid = 1'b0;
    in_if.in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_pulse", err_pulse, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_word", word_cnt, 0);
    @(negedge clk) rst = 1'b0;
    step(1'b1, 16'h0000, 1'b0);
    chk("zero_search", locked, 0);
    step(1'b1, 16'hFFFF, 1'b0);
    step(1'b1, 16'h0000, 1'b0);
    step(1'b1, 16'hCBFF, 1'b0);
    step(1'b1, 16'hD1FF, 1'b0);
    chk("lock2_at_d1ff", l2, 1);
    step(1'b1, 16'hDCFF, 1'b0);
    step(1'b0, 16'hDA7F, 1'b0);
    step(1'b0, 16'h5A5A, 1'b0);
    step(1'b1, 16'hDA7F, 1'b0);
    chk("not_locked_yet", locked, 0);
    step(1'b1, 16'hD93F, 1'b0);
    chk("locked_5th", locked, 1);
    chk("word_at_lock", word_cnt, 0);
    cur = nxt(16'hD93F);
    repeat (3) clean();
    chk("word_clean3", word_cnt, 3);
    chk("err_clean", err_cnt, 0);
    chk("pulse_clean", err_pulse, 0);
    chk("w2_sat", w2, 3);
    chk("l2_locked", l2, 1);
    step(1'b0, 16'h1111, 1'b0);
    step(1'b0, 16'h2222, 1'b0);
    chk("gap_word", word_cnt, 3);
    chk("gap_pulse", err_pulse, 0);
    bad(16'h0008);
    chk("bit3_pulse", err_pulse, 1);
    chk("bit3_err", err_cnt, 1);
    chk("bit3_word", word_cnt, 4);
    chk("bit3_locked", locked, 1);
    chk("l2_lost", l2, 0);
    chk("e2_err", e2, 1);
    clean();
    chk("after_pulse", err_pulse, 0);
    chk("after_err", err_cnt, 1);
    chk("after_locked", locked, 1);
    repeat (7) bad(16'h0001);
    chk("miss7_locked", locked, 1);
    chk("miss7_err", err_cnt, 8);
    clean();
    repeat (7) bad(16'h8001);
    chk("rerun7_locked", locked, 1);
    chk("rerun7_err", err_cnt, 15);
    bad(16'h0100);
    chk("loss_locked", locked, 0);
    chk("loss_err", err_cnt, 16);
    chk("loss_word", word_cnt, 21);
    chk("loss_pulse", err_pulse, 1);
    bad(16'h1234);
    chk("search_word", word_cnt, 21);
    chk("search_pulse", err_pulse, 0);
    repeat (4) clean();
    chk("relock_pending", locked, 0);
    clean();
    chk("relocked", locked, 1);
    chk("relock_err_hold", err_cnt, 16);
    bad(16'h0010);
    step(1'b1, cur ^ 16'h0010, 1'b1);
    cur = nxt(cur);
    chk("clr_err", err_cnt, 0);
    chk("clr_word", word_cnt, 0);
    chk("clr_pulse", err_pulse, 1);
    step(1'b1, cur, 1'b1);
    cur = nxt(cur);
    chk("clr_valid_word", word_cnt, 0);
    clean();
    chk("post_clr_word", word_cnt, 1);
`ifdef LFSR_CHK_BITERR_EN
    bad(16'h0700);
    chk("biterr_bits", bit_err_cnt, 3);
    chk("biterr_err", err_cnt, 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
